// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer input front-end.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} btn_state_t;

  localparam int DEF_DEB_CYCLES   = 500000;
  localparam int DEF_REPEAT_DELAY = 25000000;
  localparam int DEF_REPEAT_RATE  = 5000000;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One pushbutton: 2-flop synchronizer, press/release debounce FSM, optional auto-repeat.
module btn_conditioner
  import timer_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pulse
);

  localparam int DW   = cw(DEB_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = cw(RMAX);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

  logic [1:0]    sync_pipe;
  logic          key;
  btn_state_t    state;
  logic [DW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic          rphase;

  assign key = ~sync_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= 2'b11;
      state     <= IDLE;
      cnt       <= '0;
      rcnt      <= '0;
      rphase    <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], key_n};
      pulse     <= 1'b0;
      case (state)
        IDLE: if (key) begin
          cnt   <= '0;
          state <= PRESS_DEB;
        end
        PRESS_DEB: begin
          if (!key) state <= IDLE;
          else if (cnt == DEB_LAST) begin
            state  <= HELD;
            pulse  <= 1'b1;
            rcnt   <= '0;
            rphase <= 1'b0;
          end else cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
        end
        HELD: begin
          if (!key) begin
            cnt   <= '0;
            state <= REL_DEB;
          end else if (REPEAT_EN != 0) begin
            // rcnt only advances while held, so a release bounce just pauses it
            if (rcnt == (rphase ? RATE_LAST : DLY_LAST)) begin
              pulse  <= 1'b1;
              rcnt   <= '0;
              rphase <= 1'b1;
            end else rcnt <= (rcnt == '1) ? rcnt : rcnt + 1'b1;
          end
        end
        REL_DEB: begin
          if (key) state <= HELD;
          else if (cnt == DEB_LAST) state <= IDLE;
          else cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/timer_input_ctrl.sv
// Board-pin front-end: debounced single-cycle button pulses and a debounced switch level.
module timer_input_ctrl
  import timer_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_stc_n,
  input  logic key_inc_n,
  input  logic key_run_n,
  input  logic sw_raw,
  output logic stc,
  output logic inc,
  output logic run,
  output logic sw
);

  localparam int DW = cw(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(0),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_stc (.clk(clk), .rst_n(rst_n), .key_n(key_stc_n), .pulse(stc));

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(1),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_inc (.clk(clk), .rst_n(rst_n), .key_n(key_inc_n), .pulse(inc));

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(0),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_run (.clk(clk), .rst_n(rst_n), .key_n(key_run_n), .pulse(run));

  logic [1:0]    sw_pipe;
  logic          sw_pend;
  logic [DW-1:0] sw_cnt;

  // First mismatch cycle arms the counter, matching the button press latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_pipe <= 2'b00;
      sw_pend <= 1'b0;
      sw_cnt  <= '0;
      sw      <= 1'b0;
    end else begin
      sw_pipe <= {sw_pipe[0], sw_raw};
      if (sw_pipe[1] == sw) begin
        sw_pend <= 1'b0;
        sw_cnt  <= '0;
      end else if (!sw_pend) begin
        sw_pend <= 1'b1;
        sw_cnt  <= '0;
      end else if (sw_cnt == DEB_LAST) begin
        sw      <= ~sw;
        sw_pend <= 1'b0;
        sw_cnt  <= '0;
      end else sw_cnt <= (sw_cnt == '1) ? sw_cnt : sw_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_input_ctrl.sv
// Directed bench: step table with pulse counts, plus exact-timing sequences.
module tb_timer_input_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic key_stc_n, key_inc_n, key_run_n, sw_raw;
  logic stc, inc, run, sw;

  always #5 clk = ~clk;

  timer_input_ctrl #(.DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_stc_n(key_stc_n), .key_inc_n(key_inc_n), .key_run_n(key_run_n),
    .sw_raw(sw_raw),
    .stc(stc), .inc(inc), .run(run), .sw(sw)
  );

  typedef struct {
    logic stc_n;
    logic inc_n;
    logic run_n;
    logic sw_r;
    int   ticks;
    int   e_stc;
    int   e_inc;
    int   e_run;
    int   e_sw;
  } vec_t;

  vec_t tbl [14];
  int total = 0;
  int passed = 0;
  int n_stc, n_inc, n_run;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic s, input logic i, input logic r, input logic w);
    key_stc_n = s;
    key_inc_n = i;
    key_run_n = r;
    sw_raw    = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n_stc += int'(stc);
    n_inc += int'(inc);
    n_run += int'(run);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0,  5, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 30, 1, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 0, 0, 0, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0,  3, 0, 0, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0,  1, 0, 0, 0, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0,  3, 0, 0, 0, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 0, 0, 0, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 0, 0, 1, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 0, 0, 0, 0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1,  2, 0, 0, 0, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0,  2, 0, 0, 0, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 10, 0, 0, 0, 1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 0, 0, 0, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 1, 1, 1, 0};

    n_stc = 0; n_inc = 0; n_run = 0;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    #3;
    chk("rst_stc", int'(stc), 0);
    chk("rst_inc", int'(inc), 0);
    chk("rst_run", int'(run), 0);
    chk("rst_sw",  int'(sw),  0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].stc_n, tbl[i].inc_n, tbl[i].run_n, tbl[i].sw_r);
      n_stc = 0; n_inc = 0; n_run = 0;
      repeat (tbl[i].ticks) tick();
      chk($sformatf("tbl%0d_stc", i), n_stc, tbl[i].e_stc);
      chk($sformatf("tbl%0d_inc", i), n_inc, tbl[i].e_inc);
      chk($sformatf("tbl%0d_run", i), n_run, tbl[i].e_run);
      chk($sformatf("tbl%0d_sw", i),  int'(sw), tbl[i].e_sw);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (12) tick();

    // stc latency and width: pulse only at tick 7 after the drive
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk($sformatf("stc_lat_t%0d", t), int'(stc), (t == 7) ? 1 : 0);
      chk($sformatf("stc_lat_inc_t%0d", t), int'(inc), 0);
      chk($sformatf("stc_lat_run_t%0d", t), int'(run), 0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (12) tick();

    // inc held 50 ticks, then a 2-tick bounce inside release debounce
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 80; t++) begin
      tick();
      chk($sformatf("inc_rep_t%0d", t), int'(inc),
          ((t == 7) || (t >= 27 && t <= 52 && (t - 27) % 5 == 0)) ? 1 : 0);
      if (t == 50) key_inc_n = 1'b1;
      if (t == 53) key_inc_n = 1'b0;
      if (t == 55) key_inc_n = 1'b1;
    end

    // sw rise with a dropout; stable from tick 4
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 2) sw_raw = 1'b0;
      if (t == 4) sw_raw = 1'b1;
      chk($sformatf("sw_t%0d", t), int'(sw), (t >= 11) ? 1 : 0);
    end
    sw_raw = 1'b0;
    repeat (12) tick();
    chk("sw_fall", int'(sw), 0);

    // simultaneous press: all three pulse on the same tick
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk($sformatf("sim_stc_t%0d", t), int'(stc), (t == 7) ? 1 : 0);
      chk($sformatf("sim_inc_t%0d", t), int'(inc), (t == 7) ? 1 : 0);
      chk($sformatf("sim_run_t%0d", t), int'(run), (t == 7) ? 1 : 0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (12) tick();

    // reset during a repeat pulse with inc held
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (27) tick();
    chk("pre_rst_inc", int'(inc), 1);
    chk("pre_rst_sw",  int'(sw),  1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_inc", int'(inc), 0);
    chk("mid_rst_sw",  int'(sw),  0);
    chk("mid_rst_stc", int'(stc), 0);
    chk("mid_rst_run", int'(run), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int t = 1; t <= 34; t++) begin
      tick();
      chk($sformatf("post_rst_inc_t%0d", t), int'(inc),
          ((t == 7) || (t == 27) || (t == 32)) ? 1 : 0);
    end
    chk("post_rst_sw", int'(sw), 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (12) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/timer_input_ctrl.md
# timer_input_ctrl

Front-end that turns raw board pushbuttons and the direction switch into the clean control stream the timer core consumes. It outputs single-cycle `stc`, `inc` and `run` pulses and a debounced `sw` level. It sits between the board pins and the timer, which expects one pulse per press. Each input gets a two-flop synchronizer and a counter-based debouncer. `inc` also auto-repeats while held, for fast time setting.

## Interface
- `DEB_CYCLES`, default 500000: consecutive stable cycles before a level change is accepted (10 ms @ 50 MHz).
- `REPEAT_DELAY`, default 25000000: cycles from the first `inc` pulse to the first repeat pulse.
- `REPEAT_RATE`, default 5000000: cycles between successive repeat pulses.
- `clk` in 1: system clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_stc_n` in 1: raw set/select pushbutton, active-low, asynchronous.
- `key_inc_n` in 1: raw increment pushbutton, active-low, asynchronous.
- `key_run_n` in 1: raw run/pause pushbutton, active-low, asynchronous.
- `sw_raw` in 1: raw decrement-direction switch, asynchronous.
- `stc` out 1: one-cycle pulse per accepted press.
- `inc` out 1: one-cycle pulse per accepted press, plus auto-repeat pulses.
- `run` out 1: one-cycle pulse per accepted press; the timer toggles run/pause on it.
- `sw` out 1: debounced switch level.

## Operation
- Per button, an FSM with states IDLE, PRESS_DEB, HELD, REL_DEB:
  - IDLE: when the synchronized key is asserted, clear the counter and go to PRESS_DEB.
  - PRESS_DEB: count cycles while the key stays asserted. If the key deasserts, return to IDLE with no pulse. When the counter reaches DEB_CYCLES-1, go to HELD and emit one pulse.
  - HELD: when the key deasserts, clear the counter and go to REL_DEB.
  - REL_DEB: count cycles while the key stays deasserted. If the key reasserts, return to HELD with no pulse. When the counter reaches DEB_CYCLES-1, go to IDLE.
- Release never produces a pulse.
- Auto-repeat applies to `inc` only:
  - In HELD, a repeat counter starts at the press pulse.
  - First repeat pulse fires REPEAT_DELAY cycles after the press pulse.
  - Further repeat pulses fire every REPEAT_RATE cycles until the key leaves HELD.
  - Entering REL_DEB freezes the repeat counter. Returning to HELD resumes the count from where it stopped.
- `sw` debounce:
  - Output flips only after the synchronized input differs from `sw` for DEB_CYCLES consecutive cycles.
  - Any mismatch gap clears the counter.
- The three buttons are fully independent. Simultaneous presses give independent pulses, possibly in the same cycle. No priority, no lockout.
- Counter widths are `$clog2` of the largest parameter they count to, minimum 1. Counters saturate and never wrap.

## Timing
- Reset values:
  - `stc`, `inc`, `run`, `sw` = 0.
  - All FSMs in IDLE.
  - Key synchronizers = 1 (released); switch synchronizer = 0.
  - All counters = 0.
- Synchronizer latency is 2 cycles.
- Press pulse: key sampled low at edge k, held low, gives the pulse high during the cycle after edge k+DEB_CYCLES+2. The pulse is exactly 1 cycle wide.
- Glitches shorter than DEB_CYCLES cycles (after synchronization) produce no pulse and no `sw` change.
- Bounce inside REL_DEB shorter than DEB_CYCLES produces no second pulse.
- `sw` changes DEB_CYCLES+2 cycles after a stable raw change.
- Reset asserted mid-debounce or mid-repeat:
  - Outputs clear immediately (asynchronous).
  - A key still held when reset releases is treated as a new press and pulses after the normal latency.
- Outputs are registered; no combinational path from any input to any output.

## Structure
- Package `timer_pkg`:
  - `btn_state_t` enum: IDLE, PRESS_DEB, HELD, REL_DEB.
  - Default debounce and repeat constants.
- Sub-module `btn_conditioner`:
  - Contains the synchronizer, the FSM and an optional repeat counter, enabled by parameter `REPEAT_EN`.
  - Instantiated 3 times: REPEAT_EN=1 for `inc`, 0 for `stc` and `run`.
- The `sw` debouncer is a small inline counter in the top level.

## Test plan
Bench parameters for all scenarios: DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.
1. Clean `key_stc_n` press held 30 cycles, then released → exactly one `stc` pulse, 1 cycle wide, 7 cycles after the falling edge. No `inc` or `run` activity.
2. `key_run_n` low 3 cycles, high 1, low 3, high → no `run` pulse. Then low 10 cycles → exactly one `run` pulse.
3. `key_inc_n` held 50 cycles → pulses at press+0, press+20, press+25, press+30 … up to release. Release bounce of 2 cycles during REL_DEB → no extra pulse.
4. `sw_raw` 0→1 with a 2-cycle dropout after 2 cycles, then stable → `sw` rises 6 cycles after the stable point. Stays 0 throughout the dropout.
5. All three keys pressed on the same edge → `stc`, `inc`, `run` pulse in the same cycle, once each.
6. `rst_n` pulled low mid-repeat with `inc` still held → all outputs 0 at once. After reset release, a single new `inc` pulse 7 cycles later, followed by repeats on the normal schedule.
